float_divide: RTL
=================

# float_divide

IEEE-754 single-precision divider, the inverse operation of `float_multiply` in the same arithmetic datapath. It uses an iterative restoring mantissa divider with round-to-nearest-even and a start/busy/done handshake. The block computes `OUT = IN1 / IN2` in a fixed number of cycles. The operand and result formats match `float_multiply`, so the two can share an operand bus.

## Interface
- `EXP_W`, 8, exponent field width
- `MAN_W`, 23, stored mantissa width; divide iterations = `MAN_W+3`

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  request; sampled only in IDLE
- `IN1`  in  32  dividend, captured on the accepting edge
- `IN2`  in  32  divisor, captured on the accepting edge
- `OUT`  out  32  result register; holds until the next result
- `busy`  out  1  high from the cycle after accept until the done cycle (exclusive)
- `done`  out  1  one-cycle pulse; `OUT`/flags valid from this cycle
- `dz`  out  1  divide-by-zero flag, valid with `done`
- `inv`  out  1  invalid-operation flag, valid with `done`

## Operation
- States: IDLE → UNPACK → DIVIDE → ROUND → IDLE.
- The UNPACK → ROUND bypass is taken for special operands.
- **IDLE**
  - `start=1` captures the operands and moves to UNPACK.
  - `start` is ignored in every other state.
- **UNPACK** classifies the operands. Denormals are treated as zero (flush). Results by case:
  - Any NaN, 0/0, or inf/inf: `OUT=32'h7FC00000`, `inv=1`.
  - Finite nonzero / 0: signed inf, `dz=1`.
  - inf / finite: signed inf.
  - finite / inf, or 0 / nonzero: signed zero.
  - The result sign is always `IN1[31]^IN2[31]`, except for NaN.
- **Normal path**
  - Mantissas are `ma={1,man1}` and `mb={1,man2}`.
  - `e = e1 - e2 + 127`.
  - If `ma<mb`: shift `ma` left 1 and use `e-1`. The quotient is then in [1,2).
- **DIVIDE**
  - One restoring step per cycle, `MAN_W+3` = 26 iterations.
  - The iterations produce 24 quotient bits plus guard and round bits.
  - Sticky = (final remainder ≠ 0).
- **ROUND**
  - Round to nearest, ties to even.
  - A mantissa carry-out increments `e` and sets the mantissa to 0.
  - Final `e≥255` → signed inf (`dz=0`, `inv=0`).
  - Final `e≤0` → signed zero (no denormal output).
  - Writes `OUT`, `dz`, `inv`; pulses `done`; returns to IDLE.
- **Reset**
  - Values: state=IDLE, `OUT=0`, `busy=0`, `done=0`, `dz=0`, `inv=0`.
  - Reset mid-operation aborts the operation: no `done` pulse and `OUT` is zeroed.

## Timing
- Accept edge = T; `busy=1` from T+1.
- Normal operands:
  - UNPACK at edge T+1.
  - DIVIDE at edges T+2..T+27.
  - ROUND at edge T+28.
  - `done=1` in the cycle following edge T+28.
  - Latency is 28 clocks.
- Special operands: ROUND at edge T+2, so latency is 2 clocks.
- In the `done` cycle:
  - `busy=0` and the state is IDLE.
  - `start=1` here is accepted, giving back-to-back throughput of one result per 29 cycles.
- `OUT` changes only at the ROUND edge or on reset.
- `dz`/`inv` keep their values until the next ROUND.
- Operand changes after the accept edge have no effect.

## Structure
- Package `float_pkg` contains:
  - `EXP_W`, `MAN_W`, `BIAS=127`
  - `QNAN=32'h7FC00000`, `POS_INF=32'h7F800000`
  - The state enum
  - Operand-class typedef {ZERO, NORM, INF, NAN}
  - Classify function, shared with `float_multiply`
- One sub-module, `fp_round_rne`. It is combinational and takes:
  - sign, exponent, 24-bit mantissa, guard/round/sticky bits
- It returns the packed 32-bit result. Overflow and underflow saturation are also done here.
- The iteration counter and partial remainder are registers in the top module.

## Test plan
- **Normal, round-down:** `IN1=32'h415A0000` (13.625), `IN2=32'hBE200000` (−0.15625).
  - `OUT=32'hC2AE6666`, `dz=0`, `inv=0`.
  - `done` exactly 28 clocks after accept.
- **Exact and round-up:**
  - `40C00000/40000000` → `40400000` (6/2=3).
  - `3F800000/40400000` → `3EAAAAAB` (1/3, round-up).
- **Specials:**
  - `3F800000/00000000` → `7F800000`, `dz=1`.
  - `00000000/00000000` → `7FC00000`, `inv=1`.
  - `7F800000/7F800000` → `7FC00000`, `inv=1`.
  - Each with 2-clock latency.
- **Overflow/underflow:**
  - `7F7FFFFF/3F000000` → `7F800000`, `dz=0`.
  - `00800000/40000000` → `00000000`.
- **Handshake:**
  - `start` held high while busy: exactly one result.
  - `start` in the `done` cycle: second operation accepted, next `done` 29 cycles after the first.
- **Reset mid-DIVIDE:** `rst` asserted at T+10.
  - No `done` pulse; `OUT=0`, `busy=0` next cycle.
  - A subsequent `start` completes normally.

Source files
------------

// File: rtl/float_pkg.sv
// Shared definitions for the single-precision arithmetic datapath:
// field widths, special encodings, FSM states and operand classification.
package float_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int BIAS  = 127;
    localparam int ITER  = MAN_W + 3;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_UNPACK = 2'd1,
        ST_DIVIDE = 2'd2,
        ST_ROUND  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        CLS_ZERO = 2'd0,
        CLS_NORM = 2'd1,
        CLS_INF  = 2'd2,
        CLS_NAN  = 2'd3
    } fp_class_t;

    // Denormals classify as zero, so they are flushed everywhere downstream.
    function automatic fp_class_t classify(input logic [31:0] x);
        fp_class_t c;
        if (x[MAN_W+EXP_W-1:MAN_W] == {EXP_W{1'b0}}) begin
            c = CLS_ZERO;
        end else if (x[MAN_W+EXP_W-1:MAN_W] == {EXP_W{1'b1}}) begin
            if (x[MAN_W-1:0] == {MAN_W{1'b0}}) begin
                c = CLS_INF;
            end else begin
                c = CLS_NAN;
            end
        end else begin
            c = CLS_NORM;
        end
        return c;
    endfunction

endpackage

// File: rtl/fp_round_rne.sv
// Combinational round-to-nearest-even and packing of a normalised quotient,
// saturating to signed infinity on overflow and to signed zero on underflow.
module fp_round_rne
    import float_pkg::*;
(
    input  logic        i_sign,
    input  logic [9:0]  i_exp,
    input  logic [23:0] i_man,
    input  logic        i_guard,
    input  logic        i_round,
    input  logic        i_sticky,
    output logic [31:0] o_result
);

    logic        w_up;
    logic [24:0] w_sum;
    logic [9:0]  w_exp;
    logic [22:0] w_man;

    assign w_up  = i_guard & (i_round | i_sticky | i_man[0]);
    assign w_sum = {1'b0, i_man} + {24'd0, w_up};

    // Apply the mantissa carry, then saturate the biased exponent.
    always_comb begin
        w_exp    = i_exp;
        w_man    = w_sum[22:0];
        o_result = 32'd0;
        if (w_sum[24]) begin
            w_exp = i_exp + 10'd1;
            w_man = 23'd0;
        end else begin
            w_exp = i_exp;
            w_man = w_sum[22:0];
        end
        if ($signed(w_exp) >= $signed(10'd255)) begin
            o_result = {i_sign, POS_INF[30:0]};
        end else if ($signed(w_exp) <= $signed(10'd0)) begin
            o_result = {i_sign, 31'd0};
        end else begin
            o_result = {i_sign, w_exp[7:0], w_man};
        end
    end

endmodule

// File: rtl/float_divide.sv
// IEEE-754 single-precision divider: OUT = IN1 / IN2 using a restoring
// mantissa divider (one quotient bit per cycle) and RNE rounding.
module float_divide
    import float_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] IN1,
    input  logic [31:0] IN2,
    output logic [31:0] OUT,
    output logic        busy,
    output logic        done,
    output logic        dz,
    output logic        inv
);

    localparam logic [4:0] LAST_ITER = 5'(ITER - 1);

    state_t      r_state;
    state_t      w_state_nxt;

    logic [31:0] r_a;
    logic [31:0] r_b;
    logic        r_sign;
    logic [9:0]  r_exp;
    logic [23:0] r_mb;
    logic [24:0] r_rem;
    logic [25:0] r_q;
    logic [4:0]  r_cnt;
    logic        r_special;
    logic [31:0] r_spec_res;
    logic        r_spec_dz;
    logic        r_spec_inv;
    logic [31:0] r_out;
    logic        r_busy;
    logic        r_done;
    logic        r_dz;
    logic        r_inv;

    fp_class_t   w_cls_a;
    fp_class_t   w_cls_b;
    logic        w_sign;
    logic [23:0] w_ma;
    logic [23:0] w_mb;
    logic [9:0]  w_exp_raw;
    logic        w_shift;
    logic        w_is_special;
    logic [31:0] w_spec_res;
    logic        w_spec_dz;
    logic        w_spec_inv;
    logic [25:0] w_diff;
    logic        w_ge;
    logic [24:0] w_rem_sel;
    logic [31:0] w_rounded;

    assign w_cls_a   = classify(r_a);
    assign w_cls_b   = classify(r_b);
    assign w_sign    = r_a[31] ^ r_b[31];
    assign w_ma      = {1'b1, r_a[22:0]};
    assign w_mb      = {1'b1, r_b[22:0]};
    assign w_exp_raw = {2'b00, r_a[30:23]} - {2'b00, r_b[30:23]} + 10'(BIAS);
    assign w_shift   = (w_ma < w_mb);

    // Restoring step: subtract when the partial remainder covers the divisor.
    assign w_diff    = {1'b0, r_rem} - {2'b00, r_mb};
    assign w_ge      = ~w_diff[25];
    assign w_rem_sel = w_ge ? w_diff[24:0] : r_rem;

    // Special-operand results, decided once the operands are classified.
    always_comb begin
        w_is_special = 1'b1;
        w_spec_res   = QNAN;
        w_spec_dz    = 1'b0;
        w_spec_inv   = 1'b0;
        if ((w_cls_a == CLS_NAN) || (w_cls_b == CLS_NAN) ||
            ((w_cls_a == CLS_ZERO) && (w_cls_b == CLS_ZERO)) ||
            ((w_cls_a == CLS_INF) && (w_cls_b == CLS_INF))) begin
            w_spec_inv = 1'b1;
        end else if ((w_cls_a == CLS_NORM) && (w_cls_b == CLS_ZERO)) begin
            w_spec_res = {w_sign, POS_INF[30:0]};
            w_spec_dz  = 1'b1;
        end else if (w_cls_a == CLS_INF) begin
            w_spec_res = {w_sign, POS_INF[30:0]};
        end else if ((w_cls_b == CLS_INF) || (w_cls_a == CLS_ZERO)) begin
            w_spec_res = {w_sign, 31'd0};
        end else begin
            w_is_special = 1'b0;
        end
    end

    fp_round_rne u_round (
        .i_sign   (r_sign),
        .i_exp    (r_exp),
        .i_man    (r_q[25:2]),
        .i_guard  (r_q[1]),
        .i_round  (r_q[0]),
        .i_sticky (r_rem != 25'd0),
        .o_result (w_rounded)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_UNPACK;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_UNPACK: begin
                if (w_is_special) begin
                    w_state_nxt = ST_ROUND;
                end else begin
                    w_state_nxt = ST_DIVIDE;
                end
            end
            ST_DIVIDE: begin
                if (r_cnt == LAST_ITER) begin
                    w_state_nxt = ST_ROUND;
                end else begin
                    w_state_nxt = ST_DIVIDE;
                end
            end
            ST_ROUND: w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Operand capture, divide datapath and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a        <= 32'd0;
            r_b        <= 32'd0;
            r_sign     <= 1'b0;
            r_exp      <= 10'd0;
            r_mb       <= 24'd0;
            r_rem      <= 25'd0;
            r_q        <= 26'd0;
            r_cnt      <= 5'd0;
            r_special  <= 1'b0;
            r_spec_res <= 32'd0;
            r_spec_dz  <= 1'b0;
            r_spec_inv <= 1'b0;
            r_out      <= 32'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_dz       <= 1'b0;
            r_inv      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a    <= IN1;
                        r_b    <= IN2;
                        r_busy <= 1'b1;
                    end
                end
                ST_UNPACK: begin
                    r_special  <= w_is_special;
                    r_spec_res <= w_spec_res;
                    r_spec_dz  <= w_spec_dz;
                    r_spec_inv <= w_spec_inv;
                    r_sign     <= w_sign;
                    r_mb       <= w_mb;
                    r_q        <= 26'd0;
                    r_cnt      <= 5'd0;
                    // Pre-scale so the first quotient bit is always the integer 1.
                    if (w_shift) begin
                        r_exp <= w_exp_raw - 10'd1;
                        r_rem <= {w_ma, 1'b0};
                    end else begin
                        r_exp <= w_exp_raw;
                        r_rem <= {1'b0, w_ma};
                    end
                end
                ST_DIVIDE: begin
                    r_q   <= {r_q[24:0], w_ge};
                    r_rem <= w_rem_sel << 1;
                    r_cnt <= r_cnt + 5'd1;
                end
                ST_ROUND: begin
                    if (r_special) begin
                        r_out <= r_spec_res;
                        r_dz  <= r_spec_dz;
                        r_inv <= r_spec_inv;
                    end else begin
                        r_out <= w_rounded;
                        r_dz  <= 1'b0;
                        r_inv <= 1'b0;
                    end
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
                default: begin
                    r_done <= 1'b0;
                end
            endcase
        end
    end

    assign OUT  = r_out;
    assign busy = r_busy;
    assign done = r_done;
    assign dz   = r_dz;
    assign inv  = r_inv;

endmodule
